// File: rtl/mult_div_pkg.sv
// Shared multiply/divide definitions: op encoding and default latencies.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mult_div_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MADD  = 3'd5,
        MD_MTHI  = 3'd6,
        MD_MTLO  = 3'd7
    } mdOp_t;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    // Ops that use the multiplier latency window
    function automatic logic isMulOp(input mdOp_t op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD);
    endfunction

    // Ops that use the divider latency window
    function automatic logic isDivOp(input mdOp_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multiply/divide unit holding architectural HI/LO for the E stage.
// Latency: MTHI/MTLO commit at accept edge; mult/div commit MULT_CYCLES/DIV_CYCLES edges after accept.
// Backpressure: busy high while in flight; ops presented during busy are dropped, not queued.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  mdOp_t       md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        rd_hi,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   countReg;
    logic [31:0]        resHi;
    logic [31:0]        resLo;
    logic               resWr;

    logic [31:0]        nextHi;
    logic [31:0]        nextLo;
    logic               nextWr;
    logic [63:0]        prod;
    logic [31:0]        absA;
    logic [31:0]        absB;
    logic [31:0]        divisor;
    logic [31:0]        quo;
    logic [31:0]        rem;

    // Result of the op currently presented, computed from E-stage operands
    always_comb begin
        nextHi  = hi;
        nextLo  = lo;
        nextWr  = 1'b0;
        prod    = 64'd0;
        absA    = src_a;
        absB    = src_b;
        divisor = 32'd1;
        quo     = 32'd0;
        rem     = 32'd0;
        case (md_op)
            MD_MULT, MD_MADD: begin
                prod = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
                if (md_op == MD_MADD) begin
                    prod = prod + {hi, lo};
                end
                {nextHi, nextLo} = prod;
                nextWr = 1'b1;
            end
            MD_MULTU: begin
                prod = {32'd0, src_a} * {32'd0, src_b};
                {nextHi, nextLo} = prod;
                nextWr = 1'b1;
            end
            MD_DIV: begin
                // Magnitude divide then re-sign; 0x80000000 / -1 falls out as 0x80000000 rem 0
                absA    = src_a[31] ? (~src_a + 32'd1) : src_a;
                absB    = src_b[31] ? (~src_b + 32'd1) : src_b;
                divisor = (src_b == 32'd0) ? 32'd1 : absB;
                quo     = absA / divisor;
                rem     = absA % divisor;
                nextLo  = (src_a[31] ^ src_b[31]) ? (~quo + 32'd1) : quo;
                nextHi  = src_a[31] ? (~rem + 32'd1) : rem;
                nextWr  = (src_b != 32'd0);
            end
            MD_DIVU: begin
                divisor = (src_b == 32'd0) ? 32'd1 : src_b;
                nextLo  = src_a / divisor;
                nextHi  = src_a % divisor;
                nextWr  = (src_b != 32'd0);
            end
            default: begin
                nextWr = 1'b0;
            end
        endcase
    end

    // Accept/run/commit FSM; all architectural state lives here
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            countReg <= '0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            resHi    <= 32'd0;
            resLo    <= 32'd0;
            resWr    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (md_op == MD_MTHI) begin
                        hi <= src_a;
                    end else if (md_op == MD_MTLO) begin
                        lo <= src_a;
                    end else if (isMulOp(md_op) || isDivOp(md_op)) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        countReg <= isMulOp(md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        resHi    <= nextHi;
                        resLo    <= nextLo;
                        resWr    <= nextWr;
                    end
                end
                RUN: begin
                    if (countReg == CNT_W'(1)) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        countReg <= '0;
                        if (resWr) begin
                            hi <= resHi;
                            lo <= resLo;
                        end
                    end else begin
                        countReg <= countReg - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // MFHI/MFLO read port: committed values only
    assign rdata = rd_hi ? hi : lo;

endmodule
